// File: rtl/ofmap_serializer.sv
// ofmap_serializer: buffers wide array rows in a small FIFO and streams them out lane 0 first, one lane per cycle (OFMAP_RELU_EN clamps negative lanes to zero at the output)
module ofmap_serializer #(
  parameter int OFMAP_WIDTH = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] wide_dat,
  input  logic                              wide_vld,
  output logic                              wide_rdy,
  output logic [OFMAP_WIDTH-1:0]            ofmap_dat,
  output logic                              ofmap_vld,
  input  logic                              ofmap_rdy,
  output logic                              idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(ARRAY_WIDTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST = LW'(ARRAY_WIDTH - 1);
  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] lane_idx;
  logic [OFMAP_WIDTH-1:0] lane;
  logic push, take, pop;
  // handshake qualifiers; the word pops only when its last lane is taken
  always_comb begin
    wide_rdy = count != FULL;
    ofmap_vld = count != '0;
    idle = count == '0;
    push = wide_vld && wide_rdy;
    take = ofmap_vld && ofmap_rdy;
    pop = take && lane_idx == LAST;
  end
  // lane select from the head entry, optionally clamped as signed
  always_comb begin
    lane = mem[rd_ptr][lane_idx*OFMAP_WIDTH +: OFMAP_WIDTH];
`ifdef OFMAP_RELU_EN
    ofmap_dat = lane[OFMAP_WIDTH-1] ? '0 : lane;
`else
    ofmap_dat = lane;
`endif
  end
  // word storage, written on accepted pushes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    else if (push)
      mem[wr_ptr] <= wide_dat;
  // pointers, occupancy and lane position
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lane_idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (take) lane_idx <= pop ? '0 : lane_idx + 1'b1;
      count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
    end
endmodule

// File: tb/tb_ofmap_serializer.sv
// tb_ofmap_serializer: directed checks of ordering, backpressure, streaming, stalls, reset and output clamp
module tb_ofmap_serializer;
  logic clk = 0;
  logic rst_n = 0;
  logic [127:0] wide_dat = '0;
  logic wide_vld = 0;
  logic wide_rdy;
  logic [31:0] ofmap_dat;
  logic ofmap_vld;
  logic ofmap_rdy = 0;
  logic idle;
  int passes = 0;
  int checks = 0;
  ofmap_serializer dut (
    .clk(clk), .rst_n(rst_n), .wide_dat(wide_dat), .wide_vld(wide_vld), .wide_rdy(wide_rdy),
    .ofmap_dat(ofmap_dat), .ofmap_vld(ofmap_vld), .ofmap_rdy(ofmap_rdy), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [127:0] word(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction
  initial begin
    logic [31:0] relu_exp [4];
    int idx;
    int budget;
    #2;
    check("rst_wide_rdy", wide_rdy, 1);
    check("rst_vld", ofmap_vld, 0);
    check("rst_dat", ofmap_dat, 0);
    check("rst_idle", idle, 1);
    tick();
    rst_n = 1;
    tick();
    // single word
    ofmap_rdy = 1;
    wide_dat = word(32'h1);
    wide_vld = 1;
    tick();
    wide_vld = 0;
    for (int l = 0; l < 4; l++) begin
      check("single_vld", ofmap_vld, 1);
      check("single_dat", ofmap_dat, 32'h1 + l);
      tick();
    end
    check("single_vld_end", ofmap_vld, 0);
    check("single_idle_end", idle, 1);
    // backpressure: two words fill the FIFO, the third waits
    ofmap_rdy = 0;
    wide_dat = word(32'h10);
    wide_vld = 1;
    tick();
    check("bp_rdy_after1", wide_rdy, 1);
    wide_dat = word(32'h20);
    tick();
    wide_dat = word(32'h30);
    check("bp_rdy_full", wide_rdy, 0);
    tick();
    check("bp_rdy_hold", wide_rdy, 0);
    check("bp_dat_stall", ofmap_dat, 32'h10);
    ofmap_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      check("bp_vld", ofmap_vld, 1);
      check("bp_dat", ofmap_dat, (i < 4 ? 32'h10 : 32'h1c) + i);
      check("bp_wide_rdy", wide_rdy, i == 4 ? 1 : 0);
      tick();
      if (i == 4) wide_vld = 0;
    end
    for (int l = 0; l < 4; l++) begin
      check("bp_third_dat", ofmap_dat, 32'h30 + l);
      tick();
    end
    check("bp_idle", idle, 1);
    // clamp behaviour on sign boundaries
    relu_exp[1] = 32'h5;
    relu_exp[3] = 32'h7fffffff;
`ifdef OFMAP_RELU_EN
    relu_exp[0] = 32'h0;
    relu_exp[2] = 32'h0;
`else
    relu_exp[0] = 32'hffffffff;
    relu_exp[2] = 32'h80000000;
`endif
    wide_dat = {32'h7fffffff, 32'h80000000, 32'h00000005, 32'hffffffff};
    wide_vld = 1;
    tick();
    wide_vld = 0;
    for (int l = 0; l < 4; l++) begin
      check("relu_dat", ofmap_dat, relu_exp[l]);
      tick();
    end
    // streaming: one word every four cycles, no bubbles, pointers wrap
    wide_dat = word(32'h1000);
    wide_vld = 1;
    tick();
    for (int k = 0; k < 16; k++)
      for (int l = 0; l < 4; l++) begin
        wide_vld = l == 3 && k < 15;
        wide_dat = word(32'h1000 + 32'h100 * (k + 1));
        check("stream_vld", ofmap_vld, 1);
        check("stream_dat", ofmap_dat, 32'h1000 + 32'h100 * k + l);
        tick();
      end
    wide_vld = 0;
    check("stream_idle", idle, 1);
    // random stalls against a running expectation
    ofmap_rdy = 0;
    wide_dat = word(32'h200);
    wide_vld = 1;
    tick();
    wide_dat = word(32'h204);
    tick();
    wide_vld = 0;
    idx = 0;
    budget = 0;
    while (idx < 8 && budget < 300) begin
      ofmap_rdy = $urandom_range(0, 1);
      check("stall_vld", ofmap_vld, 1);
      check("stall_dat", ofmap_dat, 32'h200 + idx);
      tick();
      if (ofmap_rdy) idx++;
      budget++;
    end
    check("stall_done", idx, 8);
    ofmap_rdy = 1;
    check("stall_idle", idle, 1);
    // reset mid-word discards the remaining lanes
    wide_dat = word(32'h40);
    wide_vld = 1;
    tick();
    wide_vld = 0;
    check("mid_lane0", ofmap_dat, 32'h40);
    tick();
    check("mid_lane1", ofmap_dat, 32'h41);
    tick();
    rst_n = 0;
    #1;
    check("mid_rst_vld", ofmap_vld, 0);
    check("mid_rst_wide_rdy", wide_rdy, 1);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_dat", ofmap_dat, 0);
    tick();
    rst_n = 1;
    wide_dat = word(32'h50);
    wide_vld = 1;
    tick();
    wide_vld = 0;
    for (int l = 0; l < 4; l++) begin
      check("post_rst_dat", ofmap_dat, 32'h50 + l);
      tick();
    end
    check("post_rst_idle", idle, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ofmap_serializer.md
# ofmap_serializer

Downstream neighbour of the convolution core: accepts one full systolic-array output row (ARRAY_WIDTH partial-sum lanes of OFMAP_WIDTH bits) per handshake and streams it out one lane per cycle on the 32-bit ofmap channel with valid/ready flow control. A small FIFO of wide words decouples array drain bursts from output-side backpressure. Lane 0 is always emitted first.

## Interface

Parameters:
- OFMAP_WIDTH, 32, bits per output element (one lane).
- ARRAY_WIDTH, 4, lanes per wide word; power of two, ≥2.
- FIFO_DEPTH, 2, wide-word entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- wide_dat  in  ARRAY_WIDTH*OFMAP_WIDTH  row from the array; lane k = bits [k*OFMAP_WIDTH +: OFMAP_WIDTH].
- wide_vld  in  1  wide_dat valid.
- wide_rdy  out  1  space available for one wide word.
- ofmap_dat  out  OFMAP_WIDTH  current output element.
- ofmap_vld  out  1  ofmap_dat valid.
- ofmap_rdy  in  1  downstream accepts ofmap_dat.
- idle  out  1  FIFO empty and no lane in flight.

## Operation

- Storage: FIFO_DEPTH entries of ARRAY_WIDTH*OFMAP_WIDTH bits; write pointer, read pointer, occupancy count (0..FIFO_DEPTH, $clog2(FIFO_DEPTH)+1 bits); lane index lane_idx ($clog2(ARRAY_WIDTH) bits).
- Push: wide_vld && wide_rdy at a posedge writes wide_dat at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH.
- wide_rdy = (count != FIFO_DEPTH); depends on registered state only, never on ofmap_rdy or wide_vld.
- Output: ofmap_vld = (count != 0); ofmap_dat = lane lane_idx of entry rd_ptr (post-config-transform, see Configuration).
- Element handshake (ofmap_vld && ofmap_rdy): lane_idx increments; if lane_idx == ARRAY_WIDTH-1, lane_idx returns to 0, rd_ptr advances (wrap modulo FIFO_DEPTH), entry popped.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. When full, no push that cycle even if a pop occurs (wide_rdy already 0).
- idle = (count == 0); lane_idx is 0 whenever count == 0.
- wide_vld while wide_rdy low: ignored; the upstream must hold the word.
- ofmap_rdy while ofmap_vld low: no effect.
- States implied: EMPTY (count 0), PARTIAL, FULL (count FIFO_DEPTH); no other FSM.

## Timing

- Reset (rst_n low, any time, including mid-word): count, pointers, lane_idx → 0; storage cleared to 0; outputs immediately wide_rdy=1, ofmap_vld=0, ofmap_dat=0, idle=1. Partially emitted words are discarded.
- Latency: word pushed at edge N → ofmap_vld=1 with lane 0 during cycle after edge N (first data at N+1); no same-cycle bypass.
- Throughput: 1 element/cycle with ofmap_rdy held high; sustains one wide word per ARRAY_WIDTH cycles with no bubbles once FIFO non-empty.
- Stability: while ofmap_vld=1 and ofmap_rdy=0, ofmap_dat and lane_idx hold.
- Wide word capacity: with ofmap_rdy low, exactly FIFO_DEPTH words accepted, then wide_rdy=0.

## Configuration

- OFMAP_RELU_EN defined: ofmap_dat treats the selected lane as signed two's complement; negative values output as 0, non-negative pass unchanged. Applied combinationally at the output mux; stored data unmodified.
- OFMAP_RELU_EN undefined: lane passed bit-exact, no sign interpretation.

## Test plan

- Single word: after reset push lanes {0x1,0x2,0x3,0x4} with ofmap_rdy=1 → ofmap_dat 0x1,0x2,0x3,0x4 on 4 consecutive cycles starting one cycle after push; idle=1 afterwards.
- Backpressure: ofmap_rdy=0, push 3 words → first 2 accepted, wide_rdy=0 on third; release ofmap_rdy → 8 elements in order, then third word accepted when wide_rdy returns to 1.
- Streaming: push a word every 4 cycles for 16 words, ofmap_rdy=1 → 64 elements, ofmap_vld never drops after the first, pointer wrap correct.
- Random stall: ofmap_rdy toggled pseudo-randomly → ofmap_dat stable during stalls, output sequence matches scoreboard.
- Reset mid-operation: assert rst_n low after 2 of 4 lanes of a word → ofmap_vld=0, wide_rdy=1, idle=1 immediately; next pushed word emits from its lane 0.
- OFMAP_RELU_EN: lanes {0xFFFFFFFF, 0x00000005, 0x80000000, 0x7FFFFFFF} → defined: 0, 5, 0, 0x7FFFFFFF; undefined: values unchanged.
